// File: rtl/append_preamble.sv
// Prepends PREAMBLE_BYTES x 0x55 plus an SFD (0xD5) to every AXI-Stream frame,
// passes the payload through with zero latency, then holds off for IFG_CYCLES.
module append_preamble #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_CYCLES     = 12
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tuser,
    input  logic       saxis_tlast,
    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    input  logic       maxis_tready,
    output logic       maxis_tuser,
    output logic       maxis_tlast
);
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_GAP} state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] GAP_LAST = 8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       w_out_hs;

    assign w_out_hs = maxis_tvalid && maxis_tready;

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The pending upstream byte is left in place until DATA.
                    if (saxis_tvalid) begin
                        r_state <= S_PREAMBLE;
                        r_cnt   <= '0;
                    end
                end
                S_PREAMBLE: begin
                    if (w_out_hs) begin
                        if (r_cnt == PRE_LAST) begin
                            r_state <= S_SFD;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_SFD: begin
                    if (w_out_hs) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_out_hs && saxis_tlast) begin
                        r_state <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                        r_cnt   <= '0;
                    end
                end
                S_GAP: begin
                    // Counts wall-clock cycles; downstream backpressure is irrelevant here.
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        saxis_tready = 1'b0;
        maxis_tvalid = 1'b0;
        maxis_tdata  = 8'h00;
        maxis_tuser  = 1'b0;
        maxis_tlast  = 1'b0;
        case (r_state)
            S_PREAMBLE: begin
                maxis_tvalid = 1'b1;
                maxis_tdata  = 8'h55;
            end
            S_SFD: begin
                maxis_tvalid = 1'b1;
                maxis_tdata  = 8'hD5;
            end
            S_DATA: begin
                saxis_tready = maxis_tready;
                maxis_tvalid = saxis_tvalid;
                maxis_tdata  = saxis_tdata;
                maxis_tuser  = saxis_tuser;
                maxis_tlast  = saxis_tlast;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: doc/append_preamble.md
APPEND_PREAMBLE -- requirements
Module: append_preamble

Interface
REQ-001 SHALL have parameter PREAMBLE_BYTES, default 7: number of 0x55 preamble bytes emitted before the SFD; legal range 1..15.
REQ-002 SHALL have parameter IFG_CYCLES, default 12: minimum idle clock cycles between a frame's last byte and the next frame's first preamble byte; legal range 0..255.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port saxis_tdata, input, 8: frame byte; the CRC is already appended.
REQ-006 SHALL have port saxis_tvalid, input, 1: upstream byte valid.
REQ-007 SHALL have port saxis_tready, output, 1: this block accepts the byte.
REQ-008 SHALL have port saxis_tuser, input, 1: frame error flag; meaningful only with tlast.
REQ-009 SHALL have port saxis_tlast, input, 1: last byte of frame.
REQ-010 SHALL have ports maxis_tdata (output, 8), maxis_tvalid (output, 1), maxis_tready (input, 1), maxis_tuser (output, 1), maxis_tlast (output, 1): byte stream to the MII transmitter.

Function
REQ-011 SHALL implement FSM states IDLE, PREAMBLE, SFD, DATA, GAP.
REQ-012 IDLE: saxis_tready=0, maxis_tvalid=0; on saxis_tvalid=1 the FSM SHALL move to PREAMBLE on the next edge, and the pending byte SHALL NOT be consumed.
REQ-013 PREAMBLE: maxis_tvalid=1, maxis_tdata=0x55, tlast=0, tuser=0, saxis_tready=0; a byte counter SHALL advance only on maxis_tvalid&maxis_tready; after PREAMBLE_BYTES transfers the FSM SHALL go to SFD.
REQ-014 SFD: maxis_tvalid=1, maxis_tdata=0xD5, tlast=0, tuser=0, saxis_tready=0; on handshake the FSM SHALL go to DATA.
REQ-015 DATA: zero-latency combinational pass-through: maxis_tdata/tvalid/tuser/tlast SHALL equal the saxis_* inputs, and saxis_tready SHALL equal maxis_tready.
REQ-016 DATA: a handshake with saxis_tlast=1 SHALL move the FSM to GAP, or to IDLE if IFG_CYCLES=0.
REQ-017 DATA: a gap in saxis_tvalid SHALL produce maxis_tvalid=0 for that cycle; no filler bytes SHALL be inserted.
REQ-018 GAP: saxis_tready=0, maxis_tvalid=0; the counter SHALL count every clock cycle regardless of maxis_tready; after exactly IFG_CYCLES cycles in GAP the FSM SHALL enter IDLE.
REQ-019 Minimum spacing: the first preamble byte of the next frame SHALL NOT be presented earlier than IFG_CYCLES+1 cycles after the last-byte handshake, because IDLE costs one cycle.
REQ-020 Stall handling: while maxis_tvalid=1 and maxis_tready=0, maxis_tdata/tlast/tuser SHALL hold stable in PREAMBLE and SFD, and SHALL follow upstream in DATA, which is AXIS-stable by upstream contract.
REQ-021 A single-byte frame (tvalid with tlast on the first data byte) SHALL produce the full preamble, then SFD, then one byte with tlast=1.
REQ-022 saxis_tuser SHALL be forwarded only with the tlast byte; preamble and SFD bytes SHALL carry tuser=0.
REQ-023 The counter SHALL be 8 bits wide and SHALL be cleared on every state entry; it SHALL never wrap within legal parameter ranges.

Reset
REQ-024 With aresetn=0 sampled at an edge: FSM=IDLE, counter=0, so maxis_tvalid=0, saxis_tready=0, and maxis_tlast=0 and maxis_tuser=0 from the next cycle.
REQ-025 Reset asserted mid-frame (any state) SHALL abandon the frame with no further output bytes; after release the next frame SHALL start with a full preamble and no IFG wait.
REQ-026 Reset SHALL NOT depend on clock enable or input values.

Verification
REQ-027 Default params, maxis_tready=1, 3-byte frame 0x11,0x22,0x33(tlast): output 0x55 x7, 0xD5, 0x11, 0x22, 0x33 with tlast only on 0x33, in 11 consecutive cycles starting 1 cycle after tvalid.
REQ-028 Back-to-back two 1-byte frames, upstream always valid: exactly 12 cycles with maxis_tvalid=0 in GAP, plus 1 IDLE cycle, between frame 1 tlast and frame 2's first 0x55.
REQ-029 maxis_tready toggled 1,0,0,1 during PREAMBLE: still exactly 7 0x55 transfers; data stable during stalls; saxis_tready=0 throughout.
REQ-030 Frame ending with saxis_tuser=1: maxis_tuser=1 only on the tlast byte; all other output bytes have tuser=0.
REQ-031 aresetn=0 for 1 cycle during SFD, then a new frame 0xAB(tlast): no 0xD5 from the aborted frame; output 0x55 x7, 0xD5, 0xAB.
REQ-032 Random regression: 1000 frames of 1-24 bytes, random tvalid/tready gaps; received payload, tlast, and tuser match the sent frames; every frame preceded by 7x0x55 and 0xD5; IFG of at least 13 cycles holds.
